// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared encodings for the iterative multiply/divide sequencer.
// Operation codes, FSM states and iteration count.
package muldiv_pkg;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  localparam int MULDIV_ITERS = 32;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PREP_A = 3'd1,
    S_PREP_B = 3'd2,
    S_ITER   = 3'd3,
    S_FIX_LO = 3'd4,
    S_FIX_HI = 3'd5,
    S_DONE   = 3'd6
  } state_t;

endpackage

// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if: request/response bundle between EX stage and muldiv_seq.
// master = pipeline side, slave = sequencer side.
interface muldiv_seq_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic [1:0]       op_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             flush_i;
  logic             busy_o;
  logic             valid_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;

  modport master (
    output start_i, op_i, a_i, b_i, flush_i,
    input  busy_o, valid_o, hi_o, lo_o
  );

  modport slave (
    input  start_i, op_i, a_i, b_i, flush_i,
    output busy_o, valid_o, hi_o, lo_o
  );
endinterface

// File: rtl/muldiv_seq_adder.sv
// adder: plain WIDTH-bit two-operand adder shared by the sequencer.
// Carry-out is reconstructed by the caller from operand and sum MSBs.
module adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] s
);
  assign s = a + b;
endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: 36-cycle MULT/MULTU/DIV/DIVU sequencer on one shared adder.
// MULDIV_DIV0_FAST_EN: finish a zero-divisor divide straight from PREP_A.
import muldiv_pkg::*;

module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input logic         clk,
  input logic         rst_n,
  muldiv_seq_if.slave bus
);

  state_t           state;
  logic [1:0]       op;
  logic [WIDTH-1:0] ra, rb, hi, lo, mb;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic [4:0]       cnt;
  logic             fix_c, div0;
  logic             busy_q, valid_q;

  logic [WIDTH-1:0] add_a, add_b, sum;
  logic             cout, negb, accept;
  logic             is_div, sgn, neg_a, neg_q, neg_r;

  assign is_div = op[1];
  assign sgn    = op[0];
  assign neg_a  = sgn & ra[WIDTH-1];
  assign neg_q  = sgn & (ra[WIDTH-1] ^ rb[WIDTH-1]);
  assign neg_r  = sgn & ra[WIDTH-1];

  adder #(.WIDTH(WIDTH)) u_add (
    .a (add_a),
    .b (add_b),
    .s (sum)
  );

  assign cout = (add_a[WIDTH-1] & add_b[WIDTH-1])
              | ((add_a[WIDTH-1] ^ add_b[WIDTH-1])
                 & ~sum[WIDTH-1]);
  assign accept = hi[WIDTH-1] | cout;

  // Negation is ~x + 1 with the 1 fed through operand b.
  always_comb begin
    add_a = '0;
    add_b = '0;
    negb  = 1'b0;
    unique case (state)
      S_PREP_A: begin
        add_a = neg_a ? ~ra : ra;
        add_b = {{(WIDTH-1){1'b0}}, neg_a};
      end
      S_PREP_B: begin
        negb  = is_div ? ~(sgn & rb[WIDTH-1])
                       : (sgn & rb[WIDTH-1]);
        add_a = negb ? ~rb : rb;
        add_b = {{(WIDTH-1){1'b0}}, negb};
      end
      S_ITER: begin
        if (is_div) begin
          add_a = {hi[WIDTH-2:0], lo[WIDTH-1]};
          add_b = mb;
        end else begin
          add_a = hi;
          add_b = lo[0] ? mb : '0;
        end
      end
      S_FIX_LO: begin
        add_a = neg_q ? ~lo : lo;
        add_b = {{(WIDTH-1){1'b0}}, neg_q};
      end
      S_FIX_HI: begin
        if (is_div) begin
          add_a = neg_r ? ~hi : hi;
          add_b = {{(WIDTH-1){1'b0}}, neg_r};
        end else begin
          add_a = neg_q ? ~hi : hi;
          add_b = {{(WIDTH-1){1'b0}}, neg_q & fix_c};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      op      <= '0;
      ra      <= '0;
      rb      <= '0;
      hi      <= '0;
      lo      <= '0;
      mb      <= '0;
      cnt     <= '0;
      fix_c   <= 1'b0;
      div0    <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else if (bus.flush_i && busy_q) begin
      state  <= S_IDLE;
      busy_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (bus.start_i && !bus.flush_i) begin
            state  <= S_PREP_A;
            op     <= bus.op_i;
            ra     <= bus.a_i;
            rb     <= bus.b_i;
            div0   <= bus.op_i[1] && (bus.b_i == '0);
            busy_q <= 1'b1;
          end
        end
        S_PREP_A: begin
`ifdef MULDIV_DIV0_FAST_EN
          if (div0) begin
            state   <= S_DONE;
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
            hi_q    <= ra;
            lo_q    <= '1;
          end else
`endif
          begin
            lo    <= sum;
            hi    <= '0;
            state <= S_PREP_B;
          end
        end
        S_PREP_B: begin
          mb    <= sum;
          cnt   <= '0;
          state <= S_ITER;
        end
        S_ITER: begin
          cnt <= cnt + 5'd1;
          if (is_div) begin
            hi <= accept ? sum
                         : {hi[WIDTH-2:0], lo[WIDTH-1]};
            lo <= {lo[WIDTH-2:0], accept};
          end else begin
            hi <= {cout, sum[WIDTH-1:1]};
            lo <= {sum[0], lo[WIDTH-1:1]};
          end
          if (cnt == 5'(MULDIV_ITERS - 1))
            state <= S_FIX_LO;
        end
        S_FIX_LO: begin
          lo    <= sum;
          fix_c <= (lo == '0);
          state <= S_FIX_HI;
        end
        S_FIX_HI: begin
          state   <= S_DONE;
          busy_q  <= 1'b0;
          valid_q <= 1'b1;
          hi_q    <= div0 ? ra : sum;
          lo_q    <= div0 ? '1 : lo;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy_o  = busy_q;
  assign bus.valid_o = valid_q;
  assign bus.hi_o    = hi_q;
  assign bus.lo_o    = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed and random checks of muldiv_seq
// against a 64-bit arithmetic reference model.
import muldiv_pkg::*;

module tb_muldiv_seq;

`ifdef MULDIV_DIV0_FAST_EN
  localparam int DIV0_LAT = 1;
`else
  localparam int DIV0_LAT = 36;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  muldiv_seq_if #(.WIDTH(32)) bus ();

  muldiv_seq #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [1:0] op,
                                input logic [31:0] a,
                                input logic [31:0] b,
                                output logic [31:0] h,
                                output logic [31:0] l);
    logic [63:0] p;
    longint sa, sb;
    p = '0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op == OP_MULTU) begin
      p = {32'd0, a} * {32'd0, b};
      {h, l} = p;
    end else if (op == OP_MULT) begin
      p = 64'(sa * sb);
      {h, l} = p;
    end else if (b == 32'd0) begin
      h = a;
      l = 32'hFFFF_FFFF;
    end else if (op == OP_DIVU) begin
      l = a / b;
      h = a % b;
    end else begin
      l = 32'(sa / sb);
      h = 32'(sa % sb);
    end
  endfunction

  task automatic launch(input logic [1:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b);
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.op_i = op;
    bus.a_i = a;
    bus.b_i = b;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
  endtask

  task automatic run_op(input string tag,
                        input logic [1:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [31:0] eh,
                        input logic [31:0] el);
    int n;
    int lat;
    lat = (op[1] && b == 32'd0) ? DIV0_LAT : 36;
    launch(op, a, b);
    check({tag, "/busy0"}, 32'(bus.busy_o), 32'd1);
    n = 0;
    while (!bus.valid_o && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "/lat"}, n, lat);
    check({tag, "/hi"}, bus.hi_o, eh);
    check({tag, "/lo"}, bus.lo_o, el);
    check({tag, "/busyd"}, 32'(bus.busy_o), 32'd0);
    @(posedge clk);
    #1;
    check({tag, "/vfall"}, 32'(bus.valid_o), 32'd0);
  endtask

  task automatic run_rand(input string tag,
                          input logic [1:0] op,
                          input logic [31:0] a,
                          input logic [31:0] b);
    logic [31:0] eh, el;
    model(op, a, b, eh, el);
    run_op(tag, op, a, b, eh, el);
  endtask

  initial begin
    logic [31:0] oh, ol, a, b, eh, el;
    logic [1:0]  op;
    int n, seen;

    bus.start_i = 1'b0;
    bus.op_i = '0;
    bus.a_i = '0;
    bus.b_i = '0;
    bus.flush_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst/busy", 32'(bus.busy_o), 32'd0);
    check("rst/valid", 32'(bus.valid_o), 32'd0);
    check("rst/hi", bus.hi_o, 32'd0);
    check("rst/lo", bus.lo_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF,
           32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult_m3x7", OP_MULT, 32'hFFFF_FFFD, 32'd7,
           32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("mult_min2", OP_MULT, 32'h8000_0000,
           32'h8000_0000, 32'h4000_0000, 32'h0);
    run_op("div_m7d2", OP_DIV, 32'hFFFF_FFF9, 32'd2,
           32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu_100d7", OP_DIVU, 32'd100, 32'd7,
           32'd2, 32'd14);
    run_op("divu_by0", OP_DIVU, 32'h1234_5678, 32'd0,
           32'h1234_5678, 32'hFFFF_FFFF);
    run_op("div_by0", OP_DIV, 32'h8765_4321, 32'd0,
           32'h8765_4321, 32'hFFFF_FFFF);

    // Flush during the 10th ITER cycle (edge E12 samples it).
    oh = bus.hi_o;
    ol = bus.lo_o;
    launch(OP_MULTU, 32'd5, 32'd6);
    repeat (11) @(posedge clk);
    @(negedge clk);
    bus.flush_i = 1'b1;
    @(posedge clk);
    #1;
    bus.flush_i = 1'b0;
    check("flush/busy", 32'(bus.busy_o), 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.valid_o) seen++;
    end
    check("flush/novalid", seen, 32'd0);
    check("flush/hi", bus.hi_o, oh);
    check("flush/lo", bus.lo_o, ol);
    run_op("after_flush", OP_MULTU, 32'd5, 32'd6,
           32'd0, 32'd30);

    // Flush together with start in IDLE: nothing starts.
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.flush_i = 1'b1;
    bus.op_i = OP_MULTU;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    bus.flush_i = 1'b0;
    check("flush_start/busy", 32'(bus.busy_o), 32'd0);

    // A second start mid-operation must be ignored.
    model(OP_DIVU, 32'd1000, 32'd33, eh, el);
    launch(OP_DIVU, 32'd1000, 32'd33);
    n = 0;
    while (!bus.valid_o && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      bus.start_i = (n == 5);
      if (n == 5) begin
        bus.op_i = OP_MULTU;
        bus.a_i = 32'd9;
        bus.b_i = 32'd9;
      end
    end
    bus.start_i = 1'b0;
    check("restart/lat", n, 32'd36);
    check("restart/hi", bus.hi_o, eh);
    check("restart/lo", bus.lo_o, el);
    @(posedge clk);
    #1;
    check("restart/idle", 32'(bus.busy_o), 32'd0);

    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) b = $urandom_range(1, 20);
      if ($urandom_range(0, 9) == 0) b = 32'd0;
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      run_rand($sformatf("rand%0d", i), op, a, b);
    end

    // Reset in the middle of ITER clears everything at once.
    launch(OP_MULT, 32'd123, 32'd456);
    repeat (15) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mrst/busy", 32'(bus.busy_o), 32'd0);
    check("mrst/valid", 32'(bus.valid_o), 32'd0);
    check("mrst/hi", bus.hi_o, 32'd0);
    check("mrst/lo", bus.lo_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_rand("post_rst", OP_DIV, 32'h8000_0000,
             32'hFFFF_FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
